split_check_ctrl: RTL

- Sequencer wrapped around a bank of split constraint evaluators (split_N modules, each reducing up to 150 variable vectors to one bit x).
- Accepts candidate variable assignments over a load stream and holds them in a register bank that drives the evaluators' inputs.
- Waits a settle window, samples all split outputs, and reports pass/fail plus a failing-split mask over a result handshake.
- Keeps trial and pass counters for the solver's sampling loop.

---
 rtl/split_pkg.sv | 23 ++
 rtl/split_var_bank.sv | 40 ++++
 rtl/split_check_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/split_pkg.sv
// rtl/split_pkg.sv - shared types, defaults and helpers for the split check sequencer
package split_pkg;

    localparam int DEF_NUM_VARS   = 150;
    localparam int DEF_WORD_W     = 16;
    localparam int DEF_NUM_SPLITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    // Increment that sticks at the all-ones value of a counter 'width' bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? max_v : value + 32'd1;
    endfunction

endpackage

// File: rtl/split_var_bank.sv
// rtl/split_var_bank.sv - variable slot register file with range-checked indexed write
module split_var_bank
    import split_pkg::*;
#(
    parameter int NUM_VARS = DEF_NUM_VARS,
    parameter int WORD_W   = DEF_WORD_W,
    parameter int IDX_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [WORD_W-1:0]          wr_data,
    output logic [NUM_VARS*WORD_W-1:0] var_bus,
    output logic                       idx_err
);

    logic [WORD_W-1:0] bank [NUM_VARS];
    logic              in_range;

    // One extra bit so NUM_VARS == 2**IDX_W does not wrap the limit to zero.
    assign in_range = ({1'b0, wr_idx} < (IDX_W + 1)'(NUM_VARS));
    assign idx_err  = wr_en && !in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VARS; i++) bank[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_VARS; i++) bank[i] <= '0;
        end else if (wr_en && in_range) begin
            bank[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_VARS; g++) begin : g_flat
        assign var_bus[g*WORD_W +: WORD_W] = bank[g];
    end

endmodule

// File: rtl/split_check_ctrl.sv
// rtl/split_check_ctrl.sv - load/settle/check/report sequencer around split evaluators
module split_check_ctrl
    import split_pkg::*;
#(
    parameter int NUM_VARS   = DEF_NUM_VARS,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int IDX_W      = 8,
    parameter int NUM_SPLITS = DEF_NUM_SPLITS,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [IDX_W-1:0]           ld_idx,
    input  logic [WORD_W-1:0]          ld_data,
    input  logic                       ld_last,
    output logic [NUM_VARS*WORD_W-1:0] var_bus,
    input  logic [NUM_SPLITS-1:0]      split_en,
    input  logic [NUM_SPLITS-1:0]      split_x,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       res_pass,
    output logic [NUM_SPLITS-1:0]      res_fail_mask,
    output logic [CNT_W-1:0]           trial_cnt,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic                       err_idx
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t                state, state_n;
    logic [3:0]            settle_cnt;
    logic                  accept;
    logic                  bank_idx_err;
    logic [NUM_SPLITS-1:0] fail_now;

    assign ld_ready = (state == ST_IDLE) || (state == ST_LOAD);
    assign accept   = ld_valid && ld_ready && !clr;
    assign fail_now = split_en & ~split_x;

    split_var_bank #(
        .NUM_VARS (NUM_VARS),
        .WORD_W   (WORD_W),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .wr_en   (accept),
        .wr_idx  (ld_idx),
        .wr_data (ld_data),
        .var_bus (var_bus),
        .idx_err (bank_idx_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (clr) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (accept) state_n = ld_last ? ST_SETTLE : ST_LOAD;
                ST_LOAD:   if (accept && ld_last) state_n = ST_SETTLE;
                ST_SETTLE: if (settle_cnt == 4'd0) state_n = ST_CHECK;
                ST_CHECK:  state_n = ST_REPORT;
                ST_REPORT: if (res_valid && res_ready) state_n = ST_IDLE;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt    <= 4'd0;
            res_valid     <= 1'b0;
            res_pass      <= 1'b0;
            res_fail_mask <= '0;
            trial_cnt     <= '0;
            pass_cnt      <= '0;
            err_idx       <= 1'b0;
        end else if (clr) begin
            settle_cnt    <= 4'd0;
            res_valid     <= 1'b0;
            res_pass      <= 1'b0;
            res_fail_mask <= '0;
            trial_cnt     <= '0;
            pass_cnt      <= '0;
            err_idx       <= 1'b0;
        end else begin
            if (bank_idx_err) err_idx <= 1'b1;

            // Reload on entry so SETTLE lasts exactly SETTLE_CYC cycles.
            if (state != ST_SETTLE && state_n == ST_SETTLE) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (state == ST_CHECK) begin
                res_fail_mask <= fail_now;
                res_pass      <= (fail_now == '0);
                res_valid     <= 1'b1;
                trial_cnt     <= CNT_W'(sat_inc(32'(trial_cnt), CNT_W));
                if (fail_now == '0) pass_cnt <= CNT_W'(sat_inc(32'(pass_cnt), CNT_W));
            end

            if (state == ST_REPORT && res_valid && res_ready) res_valid <= 1'b0;
        end
    end

endmodule
